weight_pingpong_buf: RTL
========================

# weight_pingpong_buf

Parametrised, double-buffered successor to the single-bank weight buffer. The loader fills one bank while the PE array reads the other, and a request/acknowledge swap exchanges the two banks. It sits between the weight DMA/loader and the convolution PE array, so weight prefetch for the next tile can overlap compute on the current one. Width, depth and index width are parameters; the default instance matches the existing 72-bit (nine 8-bit weights), 21-entry configuration.

## Interface
- DATA_W, 72, width of one weight word
- DEPTH, 21, entries per bank (≥2)
- IDX_W, 7, index width; requires 2^IDX_W ≥ DEPTH
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe into fill bank
- wr_index  in  IDX_W  write address
- wr_data  in  DATA_W  write data
- wr_last  in  1  qualifies final write of a tile; marks fill bank FULL
- wr_ready  out  1  fill bank accepts writes (fill bank not FULL)
- wr_err  out  1  one-cycle pulse: write dropped (out of range or wr_ready=0)
- swap_req  in  1  level request to make FULL fill bank active; held until ack
- swap_ack  out  1  one-cycle pulse: swap performed this edge
- rd_en  in  1  read strobe from active bank
- rd_index  in  IDX_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated by a valid read this cycle
- act_valid  out  1  active bank holds a complete tile
- act_bank  out  1  index of bank currently read (debug)

## Operation
- Storage: two arrays of DEPTH×DATA_W, no reset on contents. State: act_sel (1 b), full[1:0]. Fill bank = ~act_sel.
- Combinational: wr_ready = !full[~act_sel]; act_valid = full[act_sel]; act_bank = act_sel.
- Write accepted when wr_en & wr_ready & wr_index < DEPTH: mem[~act_sel][wr_index] ← wr_data. If also wr_last, full[~act_sel] ← 1.
- wr_en with wr_ready=0 or wr_index ≥ DEPTH: no memory change, wr_last ignored, wr_err pulses next cycle.
- Swap accepted when swap_req & full[~act_sel]: act_sel toggles; full of the old active bank cleared (it becomes the new fill bank); swap_ack pulses next cycle. The newly active bank keeps full=1.
- Read: if rd_en & act_valid, rd_data ← (rd_index < DEPTH) ? mem[act_sel][rd_index] : 0; rd_valid ← 1. Otherwise rd_valid ← 0 and rd_data holds.
- All decisions in a cycle use pre-edge state:
  - wr_last and swap_req in the same cycle: swap rejected this cycle, accepted the next if still requested.
  - Read and swap in the same cycle: read served from the old bank.
  - A write cannot coincide with an accepted swap, because swap requires a FULL fill bank, which forces wr_ready=0.
- Reset (async): act_sel=0, full=00, rd_data=0, rd_valid=0, swap_ack=0, wr_err=0. Outputs after reset: wr_ready=1, act_valid=0, act_bank=0. Memory contents are undefined. Reset asserted mid-fill discards the partial tile.

## Timing
- Write: data stored at edge where accepted; readable only after a swap.
- Swap: accepted at edge T. swap_ack=1 in cycle after T. Reads issued from T+1 target the new bank, with data at T+2.
- Read latency 1 cycle: rd_en at edge T → rd_data/rd_valid valid after T.
- Throughput: one write and one read per cycle, concurrently, to different banks.
- wr_err and swap_ack are single-cycle pulses registered one cycle after the triggering edge.

## Test plan
- Reset then idle: rst pulse → rd_data=0, rd_valid=0, wr_ready=1, act_valid=0, act_bank=0. Read with rd_en=1 → rd_valid stays 0.
- Fill and swap: write idx 0..20 with data=idx·0x11, wr_last on idx 20 → wr_ready=0. swap_req → swap_ack one cycle, act_bank=1, act_valid=1, wr_ready=1. Read idx 5 → rd_data=0x55 one cycle later with rd_valid=1.
- Overlap: while reading bank 1 every cycle, fill bank 0 with 0xA0+idx. Reads keep returning bank-1 data. Swap → next read of idx 3 returns 0xA3, and act_bank=0.
- Backpressure/errors:
  - Write with wr_ready=0 → memory unchanged, wr_err pulse.
  - Write idx 21 → wr_err pulse.
  - Read idx 30 → rd_data=0 with rd_valid=1.
- Simultaneous events:
  - wr_last with swap_req high in the same cycle → no ack that cycle, swap_ack the following cycle.
  - Read in the swap-accept cycle → old-bank data.
- Reset mid-operation: assert rst after 10 of 21 writes and while act_valid=1 → immediately full=00, act_valid=0, wr_ready=1, rd_valid=0. A following complete fill and swap behaves normally.

Source files
------------

// File: rtl/weight_pingpong_buf.sv
// Double-buffered weight store: the loader fills one bank while the PE array reads the other;
// a request/acknowledge swap hands a complete tile to the read side.
module weight_pingpong_buf #(
    parameter int unsigned DATA_W = 72,
    parameter int unsigned DEPTH  = 21,
    parameter int unsigned IDX_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              wr_err,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              act_valid,
    output logic              act_bank
);
    localparam int unsigned    AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [2][DEPTH];

    logic       act_sel;
    logic [1:0] full;
    logic       fill_sel;
    logic       wr_in_range;
    logic       rd_in_range;
    logic       wr_ok;
    logic       swap_ok;
    logic       rd_ok;

    always_comb begin
        fill_sel    = ~act_sel;
        wr_ready    = ~full[fill_sel];
        act_valid   = full[act_sel];
        act_bank    = act_sel;
        wr_in_range = {1'b0, wr_index} < DEPTH_C;
        rd_in_range = {1'b0, rd_index} < DEPTH_C;
        wr_ok       = wr_en & wr_ready & wr_in_range;
        // A full fill bank forces wr_ready low, so wr_ok and swap_ok never coincide.
        swap_ok     = swap_req & full[fill_sel];
        rd_ok       = rd_en & act_valid;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[fill_sel][wr_index[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_sel  <= 1'b0;
            full     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            swap_ack <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_err   <= wr_en & ~wr_ok;
            swap_ack <= swap_ok;
            rd_valid <= rd_ok;
            if (wr_ok && wr_last) begin
                full[fill_sel] <= 1'b1;
            end
            // Old active bank becomes the new fill bank and loses its tile.
            if (swap_ok) begin
                act_sel       <= ~act_sel;
                full[act_sel] <= 1'b0;
            end
            if (rd_ok) begin
                rd_data <= rd_in_range ? mem[act_sel][rd_index[AW-1:0]] : '0;
            end
        end
    end
endmodule
